mux_rr_arbiter: RTL and testbench

MUX_RR_ARBITER -- requirements
Module: mux_rr_arbiter

---
 rtl/mux_rr_arbiter.sv | 176 +++++++++++++++++
 tb/tb_mux_rr_arbiter.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/mux_rr_arbiter.sv
// -----------------------------------------------------------------------------
// mux_rr_arbiter
//   Four-way round-robin arbiter with a bounded hold time, driving a 4:1 data
//   mux. The grant is registered: a request sampled at a rising edge produces
//   its grant at that edge, so there is no combinational req->gnt path.
//
//   state   | meaning
//   --------+------------------------------------------------------------
//   S_IDLE  | no owner; gnt=0, gnt_vld=0, cnt=0; arbitrate from ptr
//   S_GRANT | one owner (sel); cnt counts consecutive cycles held
//
// Ports
//   clk      in   rising-edge clock
//   rst_n    in   asynchronous active-low reset
//   req      in   [3:0] level-sensitive requests
//   din      in   [4*W-1:0] packed lanes, lane k = din[k*W +: W]
//   gnt      out  [3:0] one-hot registered grant, zero when no owner
//   sel      out  [1:0] registered index of the owner (mux select)
//   gnt_vld  out  high whenever gnt is non-zero
//   dout     out  [W-1:0] din lane [sel] when gnt_vld, else zero
// -----------------------------------------------------------------------------
module mux_rr_arbiter #(
  parameter int W       = 8,
  parameter int MAXHOLD = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [3:0]     req,
  input  logic [4*W-1:0] din,
  output logic [3:0]     gnt,
  output logic [1:0]     sel,
  output logic           gnt_vld,
  output logic [W-1:0]   dout
);

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_GRANT = 1'b1
  } state_t;

  localparam logic [3:0] MAXHOLD_C = 4'(MAXHOLD);

  state_t     state_q, state_d;
  logic [1:0] ptr_q, ptr_d;
  logic [1:0] sel_q, sel_d;
  logic [3:0] gnt_q, gnt_d;
  logic       gnt_vld_q, gnt_vld_d;
  logic [3:0] cnt_q, cnt_d;

  logic [1:0] base;
  logic       release_own;
  logic       win_found;
  logic [1:0] win_idx;
  logic [W-1:0] lane [4];

  // Returns {found, index} of the first set request at or above base,
  // wrapping 3->0. Iterating from the farthest offset down lets the nearest
  // one overwrite the result last.
  function automatic logic [2:0] rr_pick(input logic [3:0] r, input logic [1:0] b);
    logic [1:0] idx;
    logic [2:0] res;
    res = 3'b000;
    for (int i = 3; i >= 0; i--) begin
      idx = b + 2'(i);
      if (r[idx]) res = {1'b1, idx};
    end
    return res;
  endfunction

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      ptr_q     <= 2'd0;
      sel_q     <= 2'd0;
      gnt_q     <= 4'd0;
      gnt_vld_q <= 1'b0;
      cnt_q     <= 4'd0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      sel_q     <= sel_d;
      gnt_q     <= gnt_d;
      gnt_vld_q <= gnt_vld_d;
      cnt_q     <= cnt_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    release_own = 1'b0;
    base        = ptr_q;
    if (state_q == S_GRANT) begin
      release_own = !req[sel_q] || (cnt_q == MAXHOLD_C);
      // On release the pointer moves past the owner, and the same edge
      // re-arbitrates from that new pointer.
      base = sel_q + 2'd1;
    end
    {win_found, win_idx} = rr_pick(req, base);

    state_d = state_q;
    ptr_d   = ptr_q;
    case (state_q)
      S_IDLE: begin
        if (win_found) state_d = S_GRANT;
      end
      S_GRANT: begin
        if (release_own) begin
          ptr_d   = sel_q + 2'd1;
          state_d = win_found ? S_GRANT : S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output logic (next values of the registered outputs)
  // ---------------------------------------------------------------------------
  always_comb begin
    sel_d     = sel_q;
    gnt_d     = gnt_q;
    gnt_vld_d = gnt_vld_q;
    cnt_d     = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (win_found) begin
          sel_d     = win_idx;
          gnt_d     = 4'b0001 << win_idx;
          gnt_vld_d = 1'b1;
          cnt_d     = 4'd1;
        end
      end
      S_GRANT: begin
        if (release_own) begin
          if (win_found) begin
            sel_d     = win_idx;
            gnt_d     = 4'b0001 << win_idx;
            gnt_vld_d = 1'b1;
            cnt_d     = 4'd1;
          end else begin
            gnt_d     = 4'd0;
            gnt_vld_d = 1'b0;
            cnt_d     = 4'd0;
          end
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      default: begin
        gnt_d     = 4'd0;
        gnt_vld_d = 1'b0;
        cnt_d     = 4'd0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Data mux: purely combinational from registered sel/gnt_vld, so reset
  // forces dout to zero without waiting for a clock.
  // ---------------------------------------------------------------------------
  always_comb begin
    for (int k = 0; k < 4; k++) lane[k] = din[k*W +: W];
    dout = '0;
    if (gnt_vld_q) dout = lane[sel_q];
  end

  assign gnt     = gnt_q;
  assign sel     = sel_q;
  assign gnt_vld = gnt_vld_q;

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mux_rr_arbiter
//   Directed stimulus pushes the hand-computed expected outputs into a queue;
//   a monitor pops one entry per rising edge (sampled 1 time unit after the
//   edge) and compares it against the DUT outputs.
// -----------------------------------------------------------------------------
module tb_mux_rr_arbiter;

  localparam int W = 8;
  localparam logic [4*W-1:0] DIN_A   = 32'h3CA5_5AC3; // lanes 3..0: 3C A5 5A C3
  localparam logic [4*W-1:0] DIN_ALT = 32'h3C77_5AC3; // lane 2 changed to 77

  logic           clk;
  logic           rst_n;
  logic [3:0]     req;
  logic [4*W-1:0] din;
  logic [3:0]     gnt;
  logic [1:0]     sel;
  logic           gnt_vld;
  logic [W-1:0]   dout;

  typedef struct {
    logic [3:0]   gnt;
    logic [1:0]   sel;
    logic         vld;
    logic [W-1:0] dout;
    logic         chk_sel;
    string        tag;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  mux_rr_arbiter #(.W(W), .MAXHOLD(4)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req),
    .din     (din),
    .gnt     (gnt),
    .sel     (sel),
    .gnt_vld (gnt_vld),
    .dout    (dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one cycle of inputs at the falling edge and queue the outputs
  // expected after the following rising edge.
  task automatic step(input logic [3:0] r, input logic [4*W-1:0] d,
                      input logic [3:0] eg, input logic [1:0] es,
                      input logic chk_s, input string tag);
    exp_t e;
    @(negedge clk);
    req = r;
    din = d;
    e.gnt     = eg;
    e.sel     = es;
    e.vld     = (eg != 4'd0);
    e.dout    = e.vld ? d[es*W +: W] : '0;
    e.chk_sel = chk_s | e.vld;
    e.tag     = tag;
    sb.push_back(e);
  endtask

  // Monitor
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check({e.tag, ".gnt"}, 32'(gnt), 32'(e.gnt));
        check({e.tag, ".vld"}, 32'(gnt_vld), 32'(e.vld));
        check({e.tag, ".dout"}, 32'(dout), 32'(e.dout));
        if (e.chk_sel) check({e.tag, ".sel"}, 32'(sel), 32'(e.sel));
      end
    end
  end

  initial begin
    int s;
    rst_n = 1'b0;
    req   = 4'd0;
    din   = DIN_A;
    repeat (2) @(posedge clk);
    #1;
    check("reset.gnt", 32'(gnt), 32'h0);
    check("reset.sel", 32'(sel), 32'h0);
    check("reset.vld", 32'(gnt_vld), 32'h0);
    check("reset.dout", 32'(dout), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Idle for 10 cycles
    for (int i = 0; i < 10; i++) step(4'b0000, DIN_A, 4'b0000, 2'd0, 1'b1, "idle");

    // All four requesting: 0x4, 1x4, 2x4, 3x4, 0x2
    for (int k = 0; k < 18; k++) begin
      s = (k / 4) % 4;
      step(4'b1111, DIN_A, 4'b0001 << s, 2'(s), 1'b0, "rotate");
    end

    // Owner 0 (cnt 2) holds once more, then drops as req[3] rises
    step(4'b0001, DIN_A, 4'b0001, 2'd0, 1'b0, "hold0");
    step(4'b1000, DIN_A, 4'b1000, 2'd3, 1'b0, "handoff3");
    // New owner started at cnt 1: three more holds, then expiry passes to 1
    for (int i = 0; i < 3; i++) step(4'b1010, DIN_A, 4'b1000, 2'd3, 1'b0, "hold3");
    step(4'b1010, DIN_A, 4'b0010, 2'd1, 1'b0, "expire3");

    // Sole requester 1 keeps the grant across expiries
    for (int i = 0; i < 10; i++) step(4'b0010, DIN_A, 4'b0010, 2'd1, 1'b0, "solo1");

    // Other requests appear mid-grant without disturbing the owner
    step(4'b1011, DIN_A, 4'b0010, 2'd1, 1'b0, "noowner_chg");
    step(4'b1101, DIN_A, 4'b0100, 2'd2, 1'b0, "drop1");
    step(4'b0101, DIN_ALT, 4'b0100, 2'd2, 1'b0, "din_track");

    // Asynchronous reset mid-grant (owner 2, cnt 2)
    @(negedge clk);
    req   = 4'b1111;
    din   = DIN_A;
    rst_n = 1'b0;
    #1;
    check("async_rst.gnt", 32'(gnt), 32'h0);
    check("async_rst.sel", 32'(sel), 32'h0);
    check("async_rst.vld", 32'(gnt_vld), 32'h0);
    check("async_rst.dout", 32'(dout), 32'h0);
    #1;
    rst_n = 1'b1;
    begin
      exp_t e;
      e.gnt = 4'b0001; e.sel = 2'd0; e.vld = 1'b1; e.dout = 8'hC3;
      e.chk_sel = 1'b1; e.tag = "post_rst";
      sb.push_back(e);
    end
    step(4'b1111, DIN_A, 4'b0001, 2'd0, 1'b0, "post_rst_hold");
    step(4'b0000, DIN_A, 4'b0000, 2'd0, 1'b0, "to_idle");

    // Single requester 2: grant, hold, drop
    step(4'b0100, DIN_A, 4'b0100, 2'd2, 1'b0, "req2");
    step(4'b0100, DIN_A, 4'b0100, 2'd2, 1'b0, "req2_hold");
    step(4'b0000, DIN_A, 4'b0000, 2'd0, 1'b0, "req2_drop");
    step(4'b0000, DIN_A, 4'b0000, 2'd0, 1'b0, "idle_end");

    for (int i = 0; i < 5 && sb.size() > 0; i++) @(posedge clk);
    #2;
    n_cmp++;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d entries left expected 0", sb.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
